uart_cmd_ctrl: RTL and testbench

//  Frames the byte stream from the UART receiver into register-write commands.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_regfile.sv | 47 ++++
 rtl/uart_cmd_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command framer.
// Frame-state enum, sync marker default, register width and PID register map.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DHI  = 3'd2,
      DLO  = 3'd3,
      CHK  = 3'd4
   } cmd_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int         REG_W             = 16;

   localparam int REG_KP       = 0;
   localparam int REG_KI       = 1;
   localparam int REG_KD       = 2;
   localparam int REG_SETPOINT = 3;

endpackage

// File: rtl/uart_cmd_regfile.sv
// Config register file: one synchronous write port, all registers exposed flat.
// Register i appears at regs_out[REG_W*i +: REG_W].
module uart_cmd_regfile
   import uart_cmd_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int AW       = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [REG_W-1:0]          wr_data,
   output logic [NUM_REGS*REG_W-1:0] regs_out
);

   logic [REG_W-1:0] regs_q [NUM_REGS];
   logic [REG_W-1:0] regs_d [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (wr_addr == AW'(i))) begin
            regs_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_out[i*REG_W +: REG_W] = regs_q[i];
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frames UART RX bytes (SYNC, ADDR, DHI, DLO[, CHK]) into 16-bit register writes.
// Define UART_CMD_CHECKSUM_EN to require a trailing CHK byte equal to ADDR^DHI^DLO.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         NUM_REGS     = 4,
   parameter int         TIMEOUT_CLKS = 100000,
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
   localparam int        AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      reg_wr_en,
   output logic [AW-1:0]             reg_wr_addr,
   output logic [REG_W-1:0]          reg_wr_data,
   output logic [NUM_REGS*REG_W-1:0] regs_out,
   output logic                      busy,
   output logic                      frame_err
);

   localparam int            CW        = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CLKS);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CLKS - 1);

   cmd_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [7:0]       dhi_q, dhi_d;
   logic             reg_wr_en_q, reg_wr_en_d;
   logic [AW-1:0]    reg_wr_addr_q, reg_wr_addr_d;
   logic [REG_W-1:0] reg_wr_data_q, reg_wr_data_d;
   logic             frame_err_q, frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]       dlo_q, dlo_d;
   logic [7:0]       chk_q, chk_d;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      dhi_d         = dhi_q;
      reg_wr_en_d   = 1'b0;
      reg_wr_addr_d = reg_wr_addr_q;
      reg_wr_data_d = reg_wr_data_q;
      frame_err_d   = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      dlo_d         = dlo_q;
      chk_d         = chk_q;
`endif

      // Inter-byte timer: only runs while a frame is open, saturates instead of wrapping
      if ((state_q == IDLE) || rx_valid) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end

      if (rx_valid) begin
         case (state_q)
            IDLE: begin
               if (rx_data == SYNC_BYTE) begin
                  state_d = ADDR;
               end
            end
            ADDR: begin
               if (int'(rx_data) >= NUM_REGS) begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  addr_d  = rx_data[AW-1:0];
                  state_d = DHI;
`ifdef UART_CMD_CHECKSUM_EN
                  chk_d   = rx_data;
`endif
               end
            end
            DHI: begin
               dhi_d   = rx_data;
               state_d = DLO;
`ifdef UART_CMD_CHECKSUM_EN
               chk_d   = chk_q ^ rx_data;
`endif
            end
            DLO: begin
`ifdef UART_CMD_CHECKSUM_EN
               dlo_d   = rx_data;
               chk_d   = chk_q ^ rx_data;
               state_d = CHK;
`else
               reg_wr_en_d   = 1'b1;
               reg_wr_addr_d = addr_q;
               reg_wr_data_d = {dhi_q, rx_data};
               state_d       = IDLE;
`endif
            end
`ifdef UART_CMD_CHECKSUM_EN
            CHK: begin
               if (rx_data == chk_q) begin
                  reg_wr_en_d   = 1'b1;
                  reg_wr_addr_d = addr_q;
                  reg_wr_data_d = {dhi_q, dlo_q};
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
         endcase
      end else if ((state_q != IDLE) && (cnt_q == CNT_LIMIT)) begin
         frame_err_d = 1'b1;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         addr_q        <= '0;
         dhi_q         <= '0;
         reg_wr_en_q   <= 1'b0;
         reg_wr_addr_q <= '0;
         reg_wr_data_q <= '0;
         frame_err_q   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         dlo_q         <= '0;
         chk_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         dhi_q         <= dhi_d;
         reg_wr_en_q   <= reg_wr_en_d;
         reg_wr_addr_q <= reg_wr_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         frame_err_q   <= frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
         dlo_q         <= dlo_d;
         chk_q         <= chk_d;
`endif
      end
   end

   // Write port is fed from the same next-state values so regs_out updates with reg_wr_en
   uart_cmd_regfile #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (reg_wr_en_d),
      .wr_addr  (reg_wr_addr_d),
      .wr_data  (reg_wr_data_d),
      .regs_out (regs_out)
   );

   assign reg_wr_en   = reg_wr_en_q;
   assign reg_wr_addr = reg_wr_addr_q;
   assign reg_wr_data = reg_wr_data_q;
   assign frame_err   = frame_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized traffic
// compared cycle by cycle against a byte-queue reference model.
module tb_uart_cmd_ctrl;

   localparam int NUM_REGS     = 4;
   localparam int TIMEOUT_CLKS = 40;
   localparam int AW           = 2;
`ifdef UART_CMD_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int PAYLOAD_LEN = CHK_EN ? 4 : 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [7:0]             rx_data = 8'h00;
   logic                   rx_valid = 1'b0;
   logic                   reg_wr_en;
   logic [AW-1:0]          reg_wr_addr;
   logic [15:0]            reg_wr_data;
   logic [NUM_REGS*16-1:0] regs_out;
   logic                   busy;
   logic                   frame_err;

   uart_cmd_ctrl #(
      .NUM_REGS     (NUM_REGS),
      .TIMEOUT_CLKS (TIMEOUT_CLKS),
      .SYNC_BYTE    (8'hA5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .regs_out    (regs_out),
      .busy        (busy),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int obs_err_cnt = 0;
   int obs_wr_cnt = 0;

   // Reference model: open/closed frame, collected payload bytes, idle cycles since last byte
   bit          m_active;
   logic [7:0]  m_fb[$];
   int          m_since;
   logic [15:0] m_regs[NUM_REGS];
   logic [15:0] m_wr_data;
   int          m_wr_addr;
   bit          m_exp_err;
   bit          m_exp_wr;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active  = 1'b0;
      m_fb.delete();
      m_since   = 0;
      m_wr_data = 16'h0;
      m_wr_addr = 0;
      m_exp_err = 1'b0;
      m_exp_wr  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 16'h0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b);
      m_exp_err = 1'b0;
      m_exp_wr  = 1'b0;
      if (!v) begin
         if (m_active) begin
            m_since++;
            if (m_since >= TIMEOUT_CLKS) begin
               m_exp_err = 1'b1;
               m_active  = 1'b0;
            end
         end
      end else begin
         m_since = 0;
         if (!m_active) begin
            if (b == 8'hA5) begin
               m_active = 1'b1;
               m_fb.delete();
            end
         end else begin
            m_fb.push_back(b);
            if (m_fb.size() == 1 && int'(m_fb[0]) >= NUM_REGS) begin
               m_exp_err = 1'b1;
               m_active  = 1'b0;
            end else if (m_fb.size() == PAYLOAD_LEN) begin
               if (CHK_EN && (m_fb[3] != (m_fb[0] ^ m_fb[1] ^ m_fb[2]))) begin
                  m_exp_err = 1'b1;
               end else begin
                  m_exp_wr  = 1'b1;
                  m_wr_addr = int'(m_fb[0]);
                  m_wr_data = {m_fb[1], m_fb[2]};
                  m_regs[m_wr_addr] = m_wr_data;
               end
               m_active = 1'b0;
            end
         end
      end
   endtask

   task automatic compare_all(input string tag);
      logic [NUM_REGS*16-1:0] flat;
      for (int i = 0; i < NUM_REGS; i++) flat[i*16 +: 16] = m_regs[i];
      if (frame_err === 1'b1) obs_err_cnt++;
      if (reg_wr_en === 1'b1) obs_wr_cnt++;
      check_eq({tag, ".frame_err"}, 64'(frame_err), 64'(m_exp_err));
      check_eq({tag, ".reg_wr_en"}, 64'(reg_wr_en), 64'(m_exp_wr));
      check_eq({tag, ".busy"}, 64'(busy), 64'(m_active));
      check_eq({tag, ".wr_addr"}, 64'(reg_wr_addr), 64'(m_wr_addr));
      check_eq({tag, ".wr_data"}, 64'(reg_wr_data), 64'(m_wr_data));
      check_eq({tag, ".regs_out"}, 64'(regs_out), 64'(flat));
   endtask

   // Called at a negedge: present one cycle of input, then check outputs after the edge
   task automatic tick(input string tag, input bit v, input logic [7:0] b);
      rx_valid = v;
      rx_data  = b;
      @(posedge clk);
      model_step(v, b);
      @(negedge clk);
      rx_valid = 1'b0;
      compare_all(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 1'b0, 8'($urandom));
   endtask

   task automatic do_reset(input string tag);
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      compare_all(tag);
      reset = 1'b0;
   endtask

   task automatic send_frame(input string tag, input logic [7:0] a, input logic [15:0] d,
                             input bit corrupt, input int gap);
      logic [7:0] c;
      c = a ^ d[15:8] ^ d[7:0] ^ (corrupt ? 8'h01 : 8'h00);
      tick(tag, 1'b1, 8'hA5);
      idle(tag, gap);
      tick(tag, 1'b1, a);
      idle(tag, gap);
      tick(tag, 1'b1, d[15:8]);
      idle(tag, gap);
      tick(tag, 1'b1, d[7:0]);
      if (CHK_EN) begin
         idle(tag, gap);
         tick(tag, 1'b1, c);
      end
   endtask

   initial begin
      int e0, w0, r, g;
      model_reset();
      @(negedge clk);
      do_reset("reset");

      // 1: basic frame to Ki
      w0 = obs_wr_cnt;
      send_frame("t1", 8'h01, 16'h1234, 1'b0, 0);
      check_eq("t1.reg1", 64'(regs_out[31:16]), 64'h1234);
      check_eq("t1.pulses", 64'(obs_wr_cnt - w0), 64'd1);
      idle("t1", 2);

      // 2: leading junk ignored
      e0 = obs_err_cnt;
      tick("t2", 1'b1, 8'h00);
      tick("t2", 1'b1, 8'hFF);
      send_frame("t2", 8'h02, 16'hABCD, 1'b0, 0);
      check_eq("t2.reg2", 64'(regs_out[47:32]), 64'hABCD);
      check_eq("t2.no_err", 64'(obs_err_cnt - e0), 64'd0);
      idle("t2", 2);

      // 3: out-of-range address
      e0 = obs_err_cnt;
      tick("t3", 1'b1, 8'hA5);
      tick("t3", 1'b1, 8'h07);
      check_eq("t3.err_now", 64'(frame_err), 64'd1);
      check_eq("t3.busy", 64'(busy), 64'd0);
      tick("t3", 1'b1, 8'h12);
      idle("t3", 2);
      check_eq("t3.err_once", 64'(obs_err_cnt - e0), 64'd1);

      // 4: timeout mid-frame, then a good frame
      e0 = obs_err_cnt;
      tick("t4", 1'b1, 8'hA5);
      tick("t4", 1'b1, 8'h00);
      tick("t4", 1'b1, 8'h11);
      idle("t4", TIMEOUT_CLKS + 5);
      check_eq("t4.err_once", 64'(obs_err_cnt - e0), 64'd1);
      check_eq("t4.idle", 64'(busy), 64'd0);
      send_frame("t4", 8'h00, 16'h5A5A, 1'b0, 0);
      check_eq("t4.reg0", 64'(regs_out[15:0]), 64'h5A5A);
      // byte arriving exactly at the timeout limit is still accepted
      send_frame("t4b", 8'h03, 16'h0F0F, 1'b0, TIMEOUT_CLKS - 1);
      check_eq("t4b.reg3", 64'(regs_out[63:48]), 64'h0F0F);
      idle("t4", 2);

`ifdef UART_CMD_CHECKSUM_EN
      // 5: checksum mismatch, then match
      tick("t5", 1'b1, 8'hA5);
      tick("t5", 1'b1, 8'h03);
      tick("t5", 1'b1, 8'h00);
      tick("t5", 1'b1, 8'h10);
      tick("t5", 1'b1, 8'h00);
      check_eq("t5.err", 64'(frame_err), 64'd1);
      check_eq("t5.reg3_kept", 64'(regs_out[63:48]), 64'h0F0F);
      send_frame("t5", 8'h03, 16'h0010, 1'b0, 0);
      check_eq("t5.reg3", 64'(regs_out[63:48]), 64'h0010);
      idle("t5", 2);
`endif

      // 6: reset mid-frame, then back-to-back frames
      tick("t6", 1'b1, 8'hA5);
      tick("t6", 1'b1, 8'h00);
      do_reset("t6.reset");
      check_eq("t6.regs_zero", 64'(regs_out), 64'h0);
      w0 = obs_wr_cnt;
      send_frame("t6", 8'h00, 16'hBEEF, 1'b0, 0);
      send_frame("t6", 8'h01, 16'hCAFE, 1'b0, 0);
      check_eq("t6.b2b", 64'(obs_wr_cnt - w0), 64'd2);
      check_eq("t6.reg0", 64'(regs_out[15:0]), 64'hBEEF);
      check_eq("t6.reg1", 64'(regs_out[31:16]), 64'hCAFE);

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            g = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT_CLKS - 2, TIMEOUT_CLKS + 1)
                                            : $urandom_range(0, 2);
            send_frame("rnd", 8'($urandom_range(0, 5)), 16'($urandom),
                       ($urandom_range(0, 5) == 0), g);
         end else if (r <= 7) begin
            tick("rnd", 1'b1, 8'($urandom));
         end else if (r == 8) begin
            idle("rnd", $urandom_range(0, 5));
         end else begin
            tick("rnd", 1'b1, ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom));
         end
      end
      idle("tail", TIMEOUT_CLKS + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
